// File: rtl/noc_pkg.sv
// Shared NoC packet geometry, PE state encoding and Q4.12 fixed-point helpers.
// Packet layout, LSB first: dest y, dest x, src y, src x, payload.
package noc_pkg;

  localparam int X_W    = 2;
  localparam int Y_W    = 2;
  localparam int DATA_W = 8;

  function automatic int pkt_width(input int xs, input int ys, input int dw);
    return 2 * xs + 2 * ys + dw;
  endfunction

  localparam int DST_Y_LSB   = 0;
  localparam int DST_Y_W     = Y_W;
  localparam int DST_X_LSB   = DST_Y_LSB + DST_Y_W;
  localparam int DST_X_W     = X_W;
  localparam int SRC_Y_LSB   = DST_X_LSB + DST_X_W;
  localparam int SRC_Y_W     = Y_W;
  localparam int SRC_X_LSB   = SRC_Y_LSB + SRC_Y_W;
  localparam int SRC_X_W     = X_W;
  localparam int PAYLOAD_LSB = SRC_X_LSB + SRC_X_W;
  localparam int PAYLOAD_W   = DATA_W;
  localparam int PKT_W       = pkt_width(X_W, Y_W, DATA_W);

  typedef enum logic [1:0] {ACC, BIAS, SIG, OUT} neuron_state_t;

  localparam int ACC_W = 2 * DATA_W;
  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam acc_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Overflow only when both operands share a sign the wrapped sum lost.
  function automatic acc_t sat_add(input acc_t a, input acc_t b);
    acc_t s;
    acc_t r;
    s = a + b;
    r = s;
    if ((a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1])) begin
      r = a[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end
    return r;
  endfunction

  localparam logic [3*DATA_W-1:0] DEF_WEIGHTS = {3{8'h40}};

  // round(64 * sigmoid(x)), x = -8.0 + 0.5*i, entry 0 in the LSBs
  localparam logic [32*DATA_W-1:0] SIGMOID_LUT = {
    {6{8'd64}}, 8'd63, 8'd63, 8'd62, 8'd61, 8'd59, 8'd56, 8'd52, 8'd47,
    8'd40, 8'd32, 8'd24, 8'd17, 8'd12, 8'd8, 8'd5, 8'd3, 8'd2, 8'd1, 8'd1,
    {7{8'd0}}
  };

endpackage

// File: rtl/neuron_rom.sv
// Constant table with a registered read port, word 0 in the LSBs of init.
// One-cycle read latency; addresses past depth read as zero.
module neuron_rom #(
  parameter int depth = 4,
  parameter int width = 8,
  parameter file = "rom.mif",
  parameter int aw = (depth > 1) ? $clog2(depth) : 1,
  parameter logic [depth*width-1:0] init = '0
) (
  input  logic             clk,
  input  logic [aw-1:0]    addr,
  output logic [width-1:0] q
);

  if (depth < 1 || width < 1 || $bits(file) < 8) begin : g_bad_cfg
    $error("neuron_rom: bad geometry or empty source image name");
  end

  logic [width-1:0] mem [depth];

  for (genvar i = 0; i < depth; i++) begin : g_word
    assign mem[i] = init[i*width +: width];
  end

  always_ff @(posedge clk) begin
    if (int'(addr) < depth) begin
      q <= mem[addr];
    end else begin
      q <= '0;
    end
  end

endmodule

// File: rtl/noc_neuron.sv
// Single neuron PE: numWeight inputs MAC'd with saturation, bias, sigmoid LUT, one result packet.
// Last input to out_valid is 4 edges; in_ready drops while evaluating or while the result is held.
module noc_neuron
  import noc_pkg::*;
#(
  parameter int x_coord        = 'd2,
  parameter int y_coord        = 'd0,
  parameter int dest_x         = 'd3,
  parameter int dest_y         = 'd0,
  parameter int layerNo        = 2,
  parameter int neuronNo       = 1,
  parameter int numWeight      = 3,
  parameter int data_width     = DATA_W,
  parameter int x_size         = X_W,
  parameter int y_size         = Y_W,
  parameter int total_width    = pkt_width(x_size, y_size, data_width),
  parameter int weightIntWidth = 2,
  parameter int sigmoidSize    = 5,
  parameter logic [ACC_W-1:0] bias = 16'h1AA1,
  parameter weightFile         = "w_2_1.mif",
  parameter sigFile            = "sigContent.mif",
  parameter logic [numWeight*data_width-1:0] weight_init = DEF_WEIGHTS,
  parameter logic [(2**sigmoidSize)*data_width-1:0] sig_init = SIGMOID_LUT
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [total_width-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [total_width-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready
);

  if (total_width != pkt_width(x_size, y_size, data_width) || data_width != DATA_W ||
      weightIntWidth < 1 || weightIntWidth > data_width || sigmoidSize < 2 ||
      numWeight < 1 || layerNo < 0 || neuronNo < 0) begin : g_bad_cfg
    $error("noc_neuron: inconsistent parameters");
  end

  localparam int CNT_W = $clog2(numWeight + 1);
  localparam int WA_W  = (numWeight > 1) ? $clog2(numWeight) : 1;
  localparam int HDR_W = 2 * x_size + 2 * y_size;

  neuron_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  acc_t acc, acc_nxt;
  acc_t prod, pay_ext, w_ext;
  logic [data_width-1:0] payload_q, w_word, sig_q;
  logic [WA_W-1:0] w_addr;
  logic [sigmoidSize-1:0] sig_addr;
  logic s1_vld, prod_vld, accept, last_acc;
  logic out_valid_nxt;
  logic [total_width-1:0] out_data_nxt;
  logic unused_hdr;

  // The switch already routed the packet; its header carries nothing for us.
  assign unused_hdr = ^in_data[HDR_W-1:0];

  assign in_ready = (state == ACC) && (cnt < CNT_W'(numWeight));
  assign accept   = in_valid && in_ready;
  assign last_acc = prod_vld && !s1_vld && (cnt == CNT_W'(numWeight));
  assign w_addr   = WA_W'(cnt);
  assign pay_ext  = acc_t'($signed(payload_q));
  assign w_ext    = acc_t'($signed(w_word));

  // Addressed from the next accumulator value so the LUT word is ready in SIG.
  assign sig_addr = {~acc_nxt[ACC_W-1], acc_nxt[ACC_W-2 -: sigmoidSize-1]};

  neuron_rom #(
    .depth (numWeight),
    .width (data_width),
    .file  (weightFile),
    .init  (weight_init)
  ) u_weight_rom (
    .clk  (clk),
    .addr (w_addr),
    .q    (w_word)
  );

  neuron_rom #(
    .depth (2**sigmoidSize),
    .width (data_width),
    .file  (sigFile),
    .init  (sig_init)
  ) u_sig_rom (
    .clk  (clk),
    .addr (sig_addr),
    .q    (sig_q)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ACC;
      cnt       <= '0;
      acc       <= '0;
      s1_vld    <= 1'b0;
      prod_vld  <= 1'b0;
      payload_q <= '0;
      prod      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      acc       <= acc_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      s1_vld    <= accept;
      prod_vld  <= s1_vld;
      if (accept) begin
        payload_q <= in_data[total_width-1 -: data_width];
      end
      if (s1_vld) begin
        prod <= pay_ext * w_ext;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    acc_nxt       = acc;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    case (state)
      ACC: begin
        if (accept) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
        if (prod_vld) begin
          acc_nxt = sat_add(acc, prod);
        end
        if (last_acc) begin
          state_nxt = BIAS;
        end
      end
      BIAS: begin
        acc_nxt   = sat_add(acc, bias);
        state_nxt = SIG;
      end
      SIG: begin
        out_data_nxt  = {sig_q, x_coord[x_size-1:0], y_coord[y_size-1:0],
                         dest_x[x_size-1:0], dest_y[y_size-1:0]};
        out_valid_nxt = 1'b1;
        state_nxt     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          acc_nxt       = '0;
          cnt_nxt       = '0;
          state_nxt     = ACC;
        end
      end
      default: state_nxt = ACC;
    endcase
  end

endmodule

// File: tb/tb_noc_neuron.sv
// Two neurons (weights 0x40 and 0x7F) share stimulus; LUT word i is 0xA0+i so payload exposes the index.
module tb_noc_neuron;
  import noc_pkg::*;

  localparam logic [7:0] HDR = 8'h8C;  // src (2,0), dest (3,0)

  function automatic logic [32*8-1:0] mk_lut();
    logic [32*8-1:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) v[i*8 +: 8] = 8'hA0 + 8'(i);
    return v;
  endfunction

  localparam logic [32*8-1:0] TB_LUT = mk_lut();

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] in_data;
  logic        in_valid, out_ready;
  logic        rdy_a, rdy_b, vld_a, vld_b;
  logic [15:0] dat_a, dat_b;
  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  noc_neuron #(.weight_init({3{8'h40}}), .sig_init(TB_LUT)) u_a (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_a),
    .out_data(dat_a), .out_valid(vld_a), .out_ready(out_ready));

  noc_neuron #(.weight_init({3{8'h7F}}), .sig_init(TB_LUT)) u_b (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_b),
    .out_data(dat_b), .out_valid(vld_b), .out_ready(out_ready));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted result packet is popped and compared.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn && out_ready && vld_a) begin
        if (exp_a.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL a_extra: got %0h, want no packet", dat_a);
        end else check("a_pkt", dat_a, exp_a.pop_front());
      end
      if (rstn && out_ready && vld_b) begin
        if (exp_b.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL b_extra: got %0h, want no packet", dat_b);
        end else check("b_pkt", dat_b, exp_b.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] p);
    int waited;
    waited = 0;
    in_data  = {p, 8'h5A};
    in_valid = 1'b1;
    @(negedge clk);
    while (!(rdy_a && rdy_b) && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 40) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready got 0, want 1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic eval3(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                       input logic [7:0] ea, input logic [7:0] eb);
    exp_a.push_back({ea, HDR});
    exp_b.push_back({eb, HDR});
    send(p0);
    send(p1);
    send(p2);
    repeat (3) @(posedge clk);
    #1;
    check("lat_early_a", vld_a, 0);
    check("lat_early_b", vld_b, 0);
    @(posedge clk);
    #1;
    check("lat_rise_a", vld_a, 1);
    check("lat_rise_b", vld_b, 1);
  endtask

  task automatic turnaround();
    @(posedge clk);
    #1;
    check("turn_vld_a", vld_a, 0);
    check("turn_vld_b", vld_b, 0);
    check("turn_rdy_a", rdy_a, 1);
    check("turn_rdy_b", rdy_b, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation got no end, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vld", vld_a, 0);
    check("rst_dat", dat_a, 0);
    check("rst_rdy", rdy_a, 1);
    check("rst_vld_b", vld_b, 0);
    check("rst_dat_b", dat_b, 0);
    check("rst_rdy_b", rdy_b, 1);
    rstn = 1'b1;

    eval3(8'h00, 8'h00, 8'h00, 8'hB3, 8'hB3);  // bias only: acc 0x1AA1, index 19
    turnaround();
    eval3(8'h40, 8'h40, 8'hC0, 8'hB5, 8'hB7);  // a: 0x2AA1 -> 21; b: 0x3A61 -> 23
    turnaround();
    eval3(8'h7F, 8'h7F, 8'h7F, 8'hBF, 8'hBF);  // b saturates at 0x7FFF; a 0x79E1
    turnaround();
    eval3(8'h80, 8'h80, 8'h80, 8'hA7, 8'hA3);  // b floors at 0x8000 -> 0x9AA1
    turnaround();

    // Hold the result: stalled output must not move, and inputs must not leak in.
    out_ready = 1'b0;
    eval3(8'h00, 8'h00, 8'h00, 8'hB3, 8'hB3);
    in_data  = {8'h7F, 8'h5A};
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("hold_vld", vld_a, 1);
      check("hold_dat_a", dat_a, {8'hB3, HDR});
      check("hold_dat_b", dat_b, {8'hB3, HDR});
      check("hold_rdy", rdy_a, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    turnaround();
    eval3(8'h00, 8'h00, 8'h00, 8'hB3, 8'hB3);
    turnaround();

    // Abort after two inputs; the partial sum must be discarded.
    send(8'h7F);
    send(8'h7F);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    check("abort_vld", vld_a, 0);
    check("abort_dat", dat_a, 0);
    check("abort_rdy", rdy_a, 1);
    eval3(8'h00, 8'h00, 8'h00, 8'hB3, 8'hB3);
    turnaround();

    repeat (3) @(posedge clk);
    #1;
    check("drain_a", exp_a.size(), 0);
    check("drain_b", exp_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
